// File: rtl/dtfm_pkg.sv
// ============================================================================
// Module      : dtfm_pkg
// Description : Shared types and constants for the DTFM frame transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package dtfm_pkg;

  localparam int WORD_W        = 16;
  localparam int BITS_PER_WORD = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    GAP   = 2'd2,
    SHIFT = 2'd3
  } dtfm_state_e;

  // Larger of two integers, used to size the shared phase counter
  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dtfm_bit_timer.sv
// ============================================================================
// Module      : dtfm_bit_timer
// Description : Phase counter shared by the SYNC, GAP and SHIFT intervals.
//               In shift mode it alternates high/low halves of a bit and
//               emits rise, fall and end-of-bit strobes one cycle ahead of
//               the edge they announce.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dtfm_bit_timer #(
  parameter int PHASE_W = 3
) (
  input  logic               cClk,
  input  logic               reset,
  input  logic               restart,
  input  logic               shiftMode,
  input  logic [PHASE_W-1:0] limit,
  output logic               phaseDone,
  output logic               riseTick,
  output logic               fallTick,
  output logic               bitEnd
);

  logic [PHASE_W-1:0] r_phase;
  logic               r_half;   // 0 = dClk high half, 1 = dClk low half

  assign phaseDone = (r_phase == limit);
  // Outside shift mode every interval end is followed by a rising edge
  assign riseTick  = phaseDone && (!shiftMode || r_half);
  assign fallTick  = phaseDone && shiftMode && !r_half;
  assign bitEnd    = phaseDone && shiftMode && r_half;

  // Count cycles of the current interval, wrapping explicitly at the limit
  always_ff @(posedge cClk or negedge reset) begin
    if (!reset) begin
      r_phase <= '0;
      r_half  <= 1'b0;
    end else if (restart) begin
      r_phase <= '0;
      r_half  <= 1'b0;
    end else if (phaseDone) begin
      r_phase <= '0;
      r_half  <= shiftMode && !r_half;
    end else begin
      r_phase <= r_phase + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dtfm_transmitter.sv
// ============================================================================
// Module      : dtfm_transmitter
// Description : DTFM frame serializer. Sends a sync pulse, a gap, then WORDS
//               16-bit words LSB first on dClk/data. data changes only on
//               rising dClk so it is stable around every falling edge.
//               Optional frame counter: define DTFM_FRAME_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dtfm_transmitter
  import dtfm_pkg::*;
#(
  parameter int HALF_DIV = 4,
  parameter int SYNC_LEN = 8,
  parameter int WORDS    = 8
) (
  input  logic              cClk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] wordIn,
  input  logic              wordValid,
  output logic              wordReady,
  output logic              dClk,
  output logic              data,
  output logic              sync,
  output logic              busy,
  output logic              underrun
`ifdef DTFM_FRAME_CNT_EN
  ,
  output logic [15:0]       frameCnt
`endif
);

  localparam int c_PHASE_W = $clog2(maxInt(SYNC_LEN, HALF_DIV));
  localparam int c_WCNT_W  = $clog2(WORDS) + 1;
  localparam int c_BIT_W   = $clog2(BITS_PER_WORD);
  localparam logic [c_PHASE_W-1:0] c_SYNC_LIM  = c_PHASE_W'(SYNC_LEN - 1);
  localparam logic [c_PHASE_W-1:0] c_HALF_LIM  = c_PHASE_W'(HALF_DIV - 1);
  localparam logic [c_WCNT_W-1:0]  c_LAST_WORD = c_WCNT_W'(WORDS - 1);
  localparam logic [c_BIT_W-1:0]   c_LAST_BIT  = c_BIT_W'(BITS_PER_WORD - 1);

  dtfm_state_e          r_state, w_nextState;
  logic                 r_pending;
  logic [c_BIT_W-1:0]   r_bitCnt;
  logic [c_WCNT_W-1:0]  r_wordCnt;
  logic [WORD_W-1:0]    r_shift;
  logic                 r_dClk, r_data, r_sync, r_busy;
  logic                 w_load, w_frameEnd, w_enterSync, w_rise;
  logic                 w_phaseDone, w_riseTick, w_fallTick, w_bitEnd;
  logic [c_PHASE_W-1:0] w_limit;
  logic [WORD_W-1:0]    w_word;

  assign w_limit = (r_state == SYNC) ? c_SYNC_LIM : c_HALF_LIM;

  dtfm_bit_timer #(.PHASE_W(c_PHASE_W)) u_timer (
    .cClk      (cClk),
    .reset     (reset),
    .restart   (r_state == IDLE),
    .shiftMode (r_state == SHIFT),
    .limit     (w_limit),
    .phaseDone (w_phaseDone),
    .riseTick  (w_riseTick),
    .fallTick  (w_fallTick),
    .bitEnd    (w_bitEnd)
  );

  // Next-state decode plus word-load and frame-end strobes
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_frameEnd  = 1'b0;
    case (r_state)
      IDLE:  if (start || r_pending) w_nextState = SYNC;
      SYNC:  if (w_phaseDone) w_nextState = GAP;
      GAP: begin
        if (w_riseTick) begin
          w_nextState = SHIFT;
          w_load      = 1'b1;
        end
      end
      SHIFT: begin
        if (w_bitEnd && (r_bitCnt == c_LAST_BIT)) begin
          if (r_wordCnt == c_LAST_WORD) begin
            w_frameEnd  = 1'b1;
            w_nextState = (start || r_pending) ? SYNC : IDLE;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign w_enterSync = (w_nextState == SYNC) && (r_state != SYNC);
  assign w_rise      = w_load || ((r_state == SHIFT) && w_riseTick && !w_frameEnd);
  assign w_word      = wordValid ? wordIn : '0;

  // State register
  always_ff @(posedge cClk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Remember a start seen while busy; consumed when the next frame begins
  always_ff @(posedge cClk or negedge reset) begin
    if (!reset)           r_pending <= 1'b0;
    else if (w_enterSync) r_pending <= 1'b0;
    else if (start)       r_pending <= 1'b1;
  end

  // Shift register, serial data and bit/word counters
  always_ff @(posedge cClk or negedge reset) begin
    if (!reset) begin
      r_shift   <= '0;
      r_data    <= 1'b0;
      r_bitCnt  <= '0;
      r_wordCnt <= '0;
    end else if (w_load) begin
      r_shift  <= {1'b0, w_word[WORD_W-1:1]};
      r_data   <= w_word[0];
      r_bitCnt <= '0;
      if (r_state == SHIFT) r_wordCnt <= r_wordCnt + 1'b1;
    end else if ((r_state == SHIFT) && w_bitEnd) begin
      if (w_frameEnd) begin
        r_data    <= 1'b0;
        r_bitCnt  <= '0;
        r_wordCnt <= '0;
      end else begin
        r_data   <= r_shift[0];
        r_shift  <= {1'b0, r_shift[WORD_W-1:1]};
        r_bitCnt <= r_bitCnt + 1'b1;
      end
    end
  end

  // Registered link outputs so dClk, sync and busy are glitch free
  always_ff @(posedge cClk or negedge reset) begin
    if (!reset) begin
      r_dClk <= 1'b0;
      r_sync <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_sync <= (w_nextState == SYNC);
      r_busy <= (w_nextState != IDLE);
      if (w_rise)          r_dClk <= 1'b1;
      else if (w_fallTick) r_dClk <= 1'b0;
    end
  end

  assign dClk      = r_dClk;
  assign data      = r_data;
  assign sync      = r_sync;
  assign busy      = r_busy;
  assign wordReady = w_load;
  assign underrun  = w_load && !wordValid;

`ifdef DTFM_FRAME_CNT_EN
  logic [15:0] r_frameCnt;

  // Count frame starts, wrapping explicitly at the top of the range
  always_ff @(posedge cClk or negedge reset) begin
    if (!reset)           r_frameCnt <= '0;
    else if (w_enterSync) r_frameCnt <= (r_frameCnt == 16'hFFFF) ? 16'h0000 : r_frameCnt + 16'd1;
  end

  assign frameCnt = r_frameCnt;
`endif

endmodule

`default_nettype wire
